noc_param_router: RTL and testbench
===================================

// Module: noc_param_router
// PURPOSE
//  Generic 5-port mesh router (N,S,E,W,L) replacing per-position router variants (corner/edge/centre).
//  PORT_EN masks absent ports; FLIT_W and buffer depth are parameters.
//  Per-input FIFO, XY dimension-order routing, per-output round-robin arbitration, credit flow control.
//  One instance per mesh node; neighbour routers and local core attach via flattened port buses.
// PARAMETERS
//  XCOORD      0       node X coordinate, 4 bits (0..15)
//  YCOORD      0       node Y coordinate, 4 bits (0..15)
//  FLIT_W      16      flit width; header addr = flit[7:0]; FLIT_W >= 8
//  FIFO_DEPTH  4       input FIFO entries per port; power of 2, >= 2
//  CREDITS     4       initial credits per output (= downstream FIFO_DEPTH)
//  PORT_EN     5'h1F   port-present mask; bit0=N 1=S 2=E 3=W 4=L
// PORTS
//  clk            in   1           clock
//  rst            in   1           synchronous reset, active high
//  in_data        in   5*FLIT_W    input flits; port p uses [p*FLIT_W +: FLIT_W]
//  in_valid       in   5           input flit write strobe, per port
//  in_credit      out  5           1-cycle pulse to upstream: one FIFO entry freed
//  out_data       out  5*FLIT_W    output flits, same packing as in_data
//  out_valid      out  5           output flit strobe, per port
//  out_credit     in   5           1-cycle pulse from downstream: one entry freed
//  err_overflow   out  1           sticky: write to full input FIFO
//  err_misroute   out  1           sticky: flit routed to disabled port
// BEHAVIOUR
//  Reset (synchronous, overrides all): FIFOs empty, credit counters=CREDITS, RR pointers=0,
//   out_data=0, out_valid=0, in_credit=0, err_*=0.
//  Disabled port p (PORT_EN[p]=0): in_valid[p] ignored; out_valid[p], out_data[p], in_credit[p] held 0.
//  Input FIFO: in_valid writes in_data at tail; full+write -> flit dropped, err_overflow set.
//   Write and pop in the same cycle on a full FIFO is legal (no overflow).
//  Route (head flit, combinational): dx=flit[7:4], dy=flit[3:0].
//   dx>XCOORD -> E; dx<XCOORD -> W; else dy>YCOORD -> S; dy<YCOORD -> N; else L.
//   Y grows southward. Target port disabled -> head popped without output, in_credit pulsed,
//   err_misroute set. No U-turn check otherwise.
//  Arbitration per output o: requesters = non-empty inputs whose head routes to o;
//   eligible only if credit[o]>0. Round-robin from rr[o]: first requester at index >= rr[o],
//   wrapping mod 5. On grant to i: rr[o] <= (i+1) mod 5; otherwise rr[o] unchanged.
//   Each input requests exactly one output per cycle, so at most one grant per input.
//  Grant cycle t: head popped; out_data/out_valid registered -> visible t+1;
//   credit[o] decremented; in_credit[i] pulsed at t+1.
//  Latency: in_valid at t into empty FIFO, uncontended, credit>0 -> out_valid at t+2.
//  Credit counter: width clog2(CREDITS+1). Send+out_credit same cycle -> unchanged.
//   out_credit alone at CREDITS -> saturate (no wrap). Never sends at credit 0.
//  Throughput: 1 flit/cycle/output; all 5 outputs may fire in the same cycle.
//  Reset mid-transfer: in-flight flits discarded; no in_credit pulses generated for them.
// TESTING
//  T1 node(1,1): L injects dest 0x21 at t -> out_valid[E]=1 at t+2, data intact, in_credit[L] at t+2.
//  T2 N,W,L all head to L same cycle, rr=0 -> grants N,W,L over 3 consecutive cycles; rr[L] ends 0.
//  T3 CREDITS=4, out_credit held 0: 6 flits to E -> exactly 4 sent; 1 out_credit pulse -> 5th sent.
//  T4 PORT_EN=5'b11001 (SE corner): flit dest 0x31 at node(1,1) -> dropped, err_misroute=1, in_credit pulsed.
//  T5 FIFO_DEPTH=4, output blocked: 5 writes -> 5th dropped, err_overflow=1; rst -> all outputs 0, credits 4.
//  T6 simultaneous send + out_credit at credit=1 for 10 cycles -> credit stays 1, 10 flits sent.

Source files
------------

// File: rtl/noc_param_router.sv
// noc_param_router: 5-port XY mesh router with input FIFOs, round-robin arbitration and credit flow control
module noc_param_router #(
    parameter int         XCOORD     = 0,
    parameter int         YCOORD     = 0,
    parameter int         FLIT_W     = 16,
    parameter int         FIFO_DEPTH = 4,
    parameter int         CREDITS    = 4,
    parameter logic [4:0] PORT_EN    = 5'h1F
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5*FLIT_W-1:0] i_in_data,
    input  logic [4:0]          i_in_valid,
    output logic [4:0]          o_in_credit,
    output logic [5*FLIT_W-1:0] o_out_data,
    output logic [4:0]          o_out_valid,
    input  logic [4:0]          i_out_credit,
    output logic                o_err_overflow,
    output logic                o_err_misroute
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [AW:0]   FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] CMAX = CW'(CREDITS);
    localparam logic [3:0]    XC   = 4'(XCOORD);
    localparam logic [3:0]    YC   = 4'(YCOORD);

    logic [FLIT_W-1:0] r_mem [5][FIFO_DEPTH];
    logic [AW-1:0]     r_wp [5];
    logic [AW-1:0]     r_rp [5];
    logic [AW:0]       r_cnt [5];
    logic [CW-1:0]     r_cred [5];
    logic [2:0]        r_rr [5];
    logic [FLIT_W-1:0] r_odata [5];
    logic [4:0]        r_ovalid;
    logic [4:0]        r_icredit;
    logic              r_err_ovf;
    logic              r_err_mis;

    logic [FLIT_W-1:0] w_head [5];
    logic [2:0]        w_dst [5];
    logic [2:0]        w_gidx [5];
    logic [2:0]        w_idx;
    logic [4:0]        w_busy;
    logic [4:0]        w_mis;
    logic [4:0]        w_pop;
    logic [4:0]        w_wr;
    logic [4:0]        w_acc;
    logic [4:0]        w_ovf;
    logic [4:0]        w_gnt;

    // head flit of each FIFO and its XY route; a head aimed at an absent port is discarded
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            w_head[i] = r_mem[i][r_rp[i]];
            w_busy[i] = r_cnt[i] != '0;
            w_dst[i]  = (w_head[i][7:4] > XC) ? 3'd2 :
                        (w_head[i][7:4] < XC) ? 3'd3 :
                        (w_head[i][3:0] > YC) ? 3'd1 :
                        (w_head[i][3:0] < YC) ? 3'd0 : 3'd4;
            w_mis[i]  = w_busy[i] && !PORT_EN[w_dst[i]];
        end
    end

    // per-output round-robin search starting at rr[o], only while the output holds a credit
    always_comb begin
        w_pop = w_mis;
        w_gnt = '0;
        w_idx = '0;
        for (int o = 0; o < 5; o++) begin
            w_gidx[o] = '0;
            for (int k = 0; k < 5; k++) begin
                w_idx = 3'((32'(r_rr[o]) + k) % 5);
                if (!w_gnt[o] && PORT_EN[o] && r_cred[o] != '0 && w_busy[w_idx] && w_dst[w_idx] == 3'(o)) begin
                    w_gnt[o]     = 1'b1;
                    w_gidx[o]    = w_idx;
                    w_pop[w_idx] = 1'b1;
                end
            end
        end
    end

    // writes are accepted when there is room, counting a same-cycle pop as room
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            w_wr[i]  = i_in_valid[i] && PORT_EN[i];
            w_ovf[i] = w_wr[i] && r_cnt[i] == FULL && !w_pop[i];
            w_acc[i] = w_wr[i] && !w_ovf[i];
        end
    end

    // FIFO storage needs no reset: pointers and counts define validity
    always_ff @(posedge clk) begin
        for (int i = 0; i < 5; i++)
            if (w_acc[i]) r_mem[i][r_wp[i]] <= i_in_data[i*FLIT_W +: FLIT_W];
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (rst) begin
                r_wp[i]  <= '0;
                r_rp[i]  <= '0;
                r_cnt[i] <= '0;
            end else begin
                if (w_acc[i]) r_wp[i] <= r_wp[i] + 1'b1;
                if (w_pop[i]) r_rp[i] <= r_rp[i] + 1'b1;
                r_cnt[i] <= r_cnt[i] + {{AW{1'b0}}, w_acc[i]} - {{AW{1'b0}}, w_pop[i]};
            end
        end
    end

    // registered outputs, credit counters, round-robin pointers and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovalid  <= '0;
            r_icredit <= '0;
            r_err_ovf <= 1'b0;
            r_err_mis <= 1'b0;
            for (int o = 0; o < 5; o++) begin
                r_odata[o] <= '0;
                r_cred[o]  <= CMAX;
                r_rr[o]    <= '0;
            end
        end else begin
            r_ovalid  <= w_gnt;
            r_icredit <= w_pop & PORT_EN;
            r_err_ovf <= r_err_ovf || (|w_ovf);
            r_err_mis <= r_err_mis || (|w_mis);
            for (int o = 0; o < 5; o++) begin
                r_odata[o] <= w_gnt[o] ? w_head[w_gidx[o]] : '0;
                if (w_gnt[o]) r_rr[o] <= (w_gidx[o] == 3'd4) ? 3'd0 : w_gidx[o] + 3'd1;
                if (w_gnt[o] && !i_out_credit[o]) r_cred[o] <= r_cred[o] - 1'b1;
                else if (!w_gnt[o] && i_out_credit[o] && r_cred[o] != CMAX) r_cred[o] <= r_cred[o] + 1'b1;
            end
        end
    end

    // flatten the per-port output registers onto the output bus
    always_comb begin
        o_out_data = '0;
        for (int o = 0; o < 5; o++) o_out_data[o*FLIT_W +: FLIT_W] = r_odata[o];
    end

    assign o_out_valid    = r_ovalid & PORT_EN;
    assign o_in_credit    = r_icredit;
    assign o_err_overflow = r_err_ovf;
    assign o_err_misroute = r_err_mis;
endmodule

// File: tb/tb_noc_param_router.sv
// tb_noc_param_router: directed vectors, corner sequences and a queue-based reference model for the router
module tb_noc_param_router;
    localparam int NX = 1;
    localparam int NY = 1;

    typedef struct {
        int          src;
        logic [15:0] flit;
        int          port;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [79:0] in_data = '0, out_data, c_in_data = '0, c_out_data;
    logic [4:0]  in_valid = '0, in_credit, out_valid, out_credit = '0;
    logic [4:0]  c_in_valid = '0, c_in_credit, c_out_valid, c_out_credit = '0;
    logic        ovf, mis, c_ovf, c_mis;
    int          n_chk = 0;
    int          n_pass = 0;

    logic [15:0] mq [5][$];
    int          mcred [5];
    int          mrr [5];
    logic [4:0]  ev, eic;
    logic [79:0] ed;
    logic        eovf;

    always #5 clk = ~clk;

    noc_param_router #(.XCOORD(NX), .YCOORD(NY), .FLIT_W(16), .FIFO_DEPTH(4), .CREDITS(4), .PORT_EN(5'h1F)) u_dut (
        .clk(clk), .rst(rst), .i_in_data(in_data), .i_in_valid(in_valid), .o_in_credit(in_credit),
        .o_out_data(out_data), .o_out_valid(out_valid), .i_out_credit(out_credit),
        .o_err_overflow(ovf), .o_err_misroute(mis));

    noc_param_router #(.XCOORD(NX), .YCOORD(NY), .FLIT_W(16), .FIFO_DEPTH(4), .CREDITS(4), .PORT_EN(5'b11001)) u_corner (
        .clk(clk), .rst(rst), .i_in_data(c_in_data), .i_in_valid(c_in_valid), .o_in_credit(c_in_credit),
        .o_out_data(c_out_data), .o_out_valid(c_out_valid), .i_out_credit(c_out_credit),
        .o_err_overflow(c_ovf), .o_err_misroute(c_mis));

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    endtask

    task automatic rst_dut();
        @(negedge clk);
        rst = 1'b1;
        in_valid = '0;
        out_credit = '0;
        c_in_valid = '0;
        c_out_credit = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int route(input logic [7:0] a);
        int dx = int'(a[7:4]);
        int dy = int'(a[3:0]);
        if (dx > NX) return 2;
        if (dx < NX) return 3;
        if (dy > NY) return 1;
        if (dy < NY) return 0;
        return 4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            mq[i].delete();
            mcred[i] = 4;
            mrr[i] = 0;
        end
        ev = '0;
        eic = '0;
        ed = '0;
        eovf = 1'b0;
    endtask

    task automatic model_step(input logic [4:0] v, input logic [79:0] d, input logic [4:0] oc);
        int g [5];
        ev = '0;
        eic = '0;
        ed = '0;
        for (int o = 0; o < 5; o++) begin
            g[o] = -1;
            if (mcred[o] > 0)
                for (int k = 0; k < 5; k++) begin
                    int i;
                    i = (mrr[o] + k) % 5;
                    if (g[o] < 0 && mq[i].size() > 0 && route(mq[i][0][7:0]) == o) g[o] = i;
                end
        end
        for (int o = 0; o < 5; o++)
            if (g[o] >= 0) begin
                ev[o] = 1'b1;
                ed[o*16 +: 16] = mq[g[o]][0];
                eic[g[o]] = 1'b1;
            end
        for (int i = 0; i < 5; i++) if (eic[i]) void'(mq[i].pop_front());
        for (int i = 0; i < 5; i++)
            if (v[i]) begin
                if (mq[i].size() < 4) mq[i].push_back(d[i*16 +: 16]);
                else eovf = 1'b1;
            end
        for (int o = 0; o < 5; o++) begin
            if (g[o] >= 0 && !oc[o]) mcred[o]--;
            else if (g[o] < 0 && oc[o] && mcred[o] < 4) mcred[o]++;
            if (g[o] >= 0) mrr[o] = (g[o] + 1) % 5;
        end
    endtask

    initial begin
        vec_t        tbl [10];
        int          cnt;
        logic [15:0] first;
        logic [79:0] m;
        tbl[0] = '{0, 16'hA121, 2};
        tbl[1] = '{1, 16'hB201, 3};
        tbl[2] = '{2, 16'hC312, 1};
        tbl[3] = '{3, 16'hD410, 0};
        tbl[4] = '{4, 16'hE511, 4};
        tbl[5] = '{4, 16'h0021, 2};
        tbl[6] = '{2, 16'h66F0, 2};
        tbl[7] = '{0, 16'h770F, 3};
        tbl[8] = '{3, 16'h881F, 1};
        tbl[9] = '{1, 16'h9900, 3};

        rst_dut();
        chk("rst_out_valid", 80'(out_valid), 80'(0));
        chk("rst_out_data", out_data, 80'(0));
        chk("rst_in_credit", 80'(in_credit), 80'(0));
        chk("rst_errs", 80'({ovf, mis, c_ovf, c_mis}), 80'(0));

        foreach (tbl[v]) begin
            rst_dut();
            @(negedge clk);
            in_valid = 5'(1 << tbl[v].src);
            in_data = '0;
            in_data[tbl[v].src*16 +: 16] = tbl[v].flit;
            @(negedge clk);
            in_valid = '0;
            chk("tbl_early_valid", 80'(out_valid), 80'(0));
            @(negedge clk);
            chk("tbl_port", 80'(out_valid), 80'(1 << tbl[v].port));
            chk("tbl_data", 80'(out_data[tbl[v].port*16 +: 16]), 80'(tbl[v].flit));
            chk("tbl_in_credit", 80'(in_credit), 80'(1 << tbl[v].src));
            @(negedge clk);
            chk("tbl_idle", 80'({out_valid, in_credit}), 80'(0));
        end

        rst_dut();
        out_credit = 5'b10000;
        @(negedge clk);
        in_valid = 5'b11001;
        in_data = '0;
        in_data[0 +: 16] = 16'hA011;
        in_data[48 +: 16] = 16'hB011;
        in_data[64 +: 16] = 16'hC011;
        @(negedge clk);
        in_valid = '0;
        @(negedge clk);
        chk("t2_g0_valid", 80'(out_valid), 80'(5'b10000));
        chk("t2_g0_data", 80'(out_data[64 +: 16]), 80'(16'hA011));
        chk("t2_g0_credit", 80'(in_credit), 80'(5'b00001));
        @(negedge clk);
        chk("t2_g1_data", 80'(out_data[64 +: 16]), 80'(16'hB011));
        chk("t2_g1_credit", 80'(in_credit), 80'(5'b01000));
        @(negedge clk);
        chk("t2_g2_data", 80'(out_data[64 +: 16]), 80'(16'hC011));
        chk("t2_g2_credit", 80'(in_credit), 80'(5'b10000));
        in_valid = 5'b11000;
        in_data[48 +: 16] = 16'hD011;
        in_data[64 +: 16] = 16'hE011;
        @(negedge clk);
        in_valid = '0;
        chk("t2_gap", 80'(out_valid), 80'(0));
        @(negedge clk);
        chk("t2_rr_w_first", 80'(out_data[64 +: 16]), 80'(16'hD011));
        @(negedge clk);
        chk("t2_rr_l_second", 80'(out_data[64 +: 16]), 80'(16'hE011));
        out_credit = '0;

        rst_dut();
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid[2]) cnt++;
            in_valid = (c < 6) ? 5'b10000 : 5'b00000;
            in_data[64 +: 16] = {8'(8'h30 + c), 8'h21};
        end
        chk("t3_sent_no_credit", 80'(cnt), 80'(4));
        @(negedge clk);
        out_credit = 5'b00100;
        @(negedge clk);
        out_credit = '0;
        cnt = 0;
        first = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid[2]) begin
                cnt++;
                first = out_data[32 +: 16];
            end
        end
        chk("t3_one_more", 80'(cnt), 80'(1));
        chk("t3_fifth_data", 80'(first), 80'(16'h3421));
        chk("t3_no_ovf", 80'(ovf), 80'(0));

        rst_dut();
        @(negedge clk);
        c_in_valid = 5'b10000;
        c_in_data = '0;
        c_in_data[64 +: 16] = 16'h0031;
        @(negedge clk);
        c_in_valid = '0;
        chk("t4_mis_before", 80'({c_mis, c_in_credit}), 80'(0));
        @(negedge clk);
        chk("t4_misroute", 80'(c_mis), 80'(1));
        chk("t4_in_credit", 80'(c_in_credit), 80'(5'b10000));
        chk("t4_no_out", 80'(c_out_valid), 80'(0));
        @(negedge clk);
        chk("t4_sticky", 80'({c_mis, c_in_credit}), 80'(6'b100000));
        c_in_valid = 5'b00100;
        c_in_data[32 +: 16] = 16'h0011;
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            c_in_valid = '0;
            if (c_out_valid != 0 || c_in_credit != 0) cnt++;
        end
        chk("t4_disabled_in", 80'(cnt), 80'(0));

        rst_dut();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            in_valid = 5'b10000;
            in_data[64 +: 16] = {8'(8'h40 + c), 8'h21};
        end
        @(negedge clk);
        in_valid = '0;
        repeat (5) @(negedge clk);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c > 0) chk("t5_ovf", 80'(ovf), 80'(c == 5));
            in_valid = (c < 5) ? 5'b10000 : 5'b00000;
            in_data[64 +: 16] = {8'(8'h50 + c), 8'h21};
        end
        out_credit = 5'b00100;
        rst_dut();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t5_rst_valid", 80'({out_valid, in_credit}), 80'(0));
            chk("t5_rst_data", out_data, 80'(0));
            chk("t5_rst_ovf", 80'(ovf), 80'(0));
        end
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid[2]) cnt++;
            in_valid = (c < 5) ? 5'b10000 : 5'b00000;
            in_data[64 +: 16] = {8'(8'h60 + c), 8'h21};
        end
        chk("t5_credits_reset", 80'(cnt), 80'(4));

        rst_dut();
        cnt = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (out_valid[2]) cnt++;
            in_valid = (c < 13) ? 5'b10000 : 5'b00000;
            in_data[64 +: 16] = {8'(8'h70 + c), 8'h21};
            out_credit = (c >= 4 && c < 14) ? 5'b00100 : 5'b00000;
        end
        chk("t6_sent", 80'(cnt), 80'(13));
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid[2]) cnt++;
            in_valid = (c < 2) ? 5'b10000 : 5'b00000;
        end
        chk("t6_credit_one", 80'(cnt), 80'(1));

        rst_dut();
        model_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            m = '0;
            for (int o = 0; o < 5; o++) m[o*16 +: 16] = {16{ev[o]}};
            chk("rnd_valid", 80'(out_valid), 80'(ev));
            chk("rnd_data", out_data & m, ed & m);
            chk("rnd_in_credit", 80'(in_credit), 80'(eic));
            chk("rnd_ovf", 80'(ovf), 80'(eovf));
            in_valid = 5'($urandom);
            out_credit = 5'($urandom);
            for (int i = 0; i < 5; i++)
                in_data[i*16 +: 16] = {8'($urandom), 4'($urandom_range(0, 2)), 4'($urandom_range(0, 2))};
            model_step(in_valid, in_data, out_credit);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
